// File: rtl/qc_ldpc_encoder_if.sv
// Stream bundle of the QC-LDPC encoder: message input, generator ROM read port
// and parity output. The master side is the encoder itself.
interface qc_ldpc_encoder_if #(
    parameter int unsigned Z  = 64,
    parameter int unsigned MB = 24,
    parameter int unsigned AW = 7
);
    logic            msg_valid;
    logic            msg_ready;
    logic [Z-1:0]    msg_data;
    logic            gen_rd;
    logic [AW-1:0]   gen_addr;
    logic [MB*Z-1:0] gen_data;
    logic            par_valid;
    logic            par_ready;
    logic [Z-1:0]    par_data;

    modport master (
        input  msg_valid, msg_data, gen_data, par_ready,
        output msg_ready, gen_rd, gen_addr, par_valid, par_data
    );

    modport slave (
        output msg_valid, msg_data, gen_data, par_ready,
        input  msg_ready, gen_rd, gen_addr, par_valid, par_data
    );
endinterface

// File: rtl/qc_ldpc_encoder.sv
// Systematic QC-LDPC parity encoder: bit-serial shift-register-adder-accumulator
// updating all MB parity blocks in parallel, parity streamed out Z bits per beat.
module qc_ldpc_encoder #(
    parameter int unsigned Z  = 64,
    parameter int unsigned KB = 120,
    parameter int unsigned MB = 24,
    parameter int unsigned AW = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    qc_ldpc_encoder_if.master bus
);
    localparam int unsigned JW = (KB > 1) ? $clog2(KB) : 1;
    localparam int unsigned KW = (Z > 1) ? $clog2(Z) : 1;
    localparam int unsigned PW = (MB > 1) ? $clog2(MB) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MSG,
        S_ACCUM,
        S_OUTPUT,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [MB-1:0][Z-1:0] acc_q, acc_d;
    logic [MB-1:0][Z-1:0] circ_q, circ_d;
    logic [Z-1:0]         msg_sh_q, msg_sh_d;
    logic [JW-1:0]        j_q, j_d;
    logic [KW-1:0]        k_q, k_d;
    logic [PW-1:0]        p_q, p_d;
    logic                 first_q;

    logic                 msg_ready_q, msg_ready_d;
    logic                 gen_rd_q, gen_rd_d;
    logic [AW-1:0]        gen_addr_q, gen_addr_d;
    logic                 par_valid_q, par_valid_d;
    logic [Z-1:0]         par_data_q, par_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic last_k, last_j, last_p, msg_fire, par_fire;

    assign last_k   = (k_q == KW'(Z - 1));
    assign last_j   = (j_q == JW'(KB - 1));
    assign last_p   = (p_q == PW'(MB - 1));
    assign msg_fire = bus.msg_valid && msg_ready_q;
    assign par_fire = par_valid_q && bus.par_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_FETCH;
            S_FETCH:    state_d = S_WAIT_MSG;
            S_WAIT_MSG: if (msg_fire) state_d = S_ACCUM;
            S_ACCUM:    if (last_k) state_d = last_j ? S_OUTPUT : S_FETCH;
            S_OUTPUT:   if (par_fire && last_p) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every port leaves a flop
    always_comb begin
        msg_ready_d = 1'b0;
        gen_rd_d    = 1'b0;
        gen_addr_d  = gen_addr_q;
        par_valid_d = 1'b0;
        par_data_d  = '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = 1'b0;
        case (state_d)
            S_FETCH: begin
                gen_rd_d   = 1'b1;
                gen_addr_d = AW'(j_d);
            end
            S_WAIT_MSG: msg_ready_d = 1'b1;
            S_OUTPUT: begin
                par_valid_d = 1'b1;
                par_data_d  = acc_d[p_d];
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // SRAA datapath and block/bit/parity counters
    always_comb begin
        acc_d    = acc_q;
        circ_d   = circ_q;
        msg_sh_d = msg_sh_q;
        j_d      = j_q;
        k_d      = k_q;
        p_d      = p_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    j_d   = '0;
                end
            end
            S_WAIT_MSG: begin
                // ROM data is only valid in the cycle right after the read strobe
                if (first_q) circ_d = bus.gen_data;
                if (msg_fire) begin
                    msg_sh_d = bus.msg_data;
                    k_d      = '0;
                end
            end
            S_ACCUM: begin
                for (int unsigned i = 0; i < MB; i++) begin
                    if (msg_sh_q[0]) acc_d[i] = acc_q[i] ^ circ_q[i];
                    circ_d[i] = {circ_q[i][Z-2:0], circ_q[i][Z-1]};
                end
                msg_sh_d = msg_sh_q >> 1;
                if (last_k) begin
                    if (last_j) p_d = '0;
                    else        j_d = j_q + JW'(1);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_OUTPUT: begin
                if (par_fire && !last_p) p_d = p_q + PW'(1);
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            circ_q      <= '0;
            msg_sh_q    <= '0;
            j_q         <= '0;
            k_q         <= '0;
            p_q         <= '0;
            first_q     <= 1'b0;
            msg_ready_q <= 1'b0;
            gen_rd_q    <= 1'b0;
            gen_addr_q  <= '0;
            par_valid_q <= 1'b0;
            par_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            circ_q      <= circ_d;
            msg_sh_q    <= msg_sh_d;
            j_q         <= j_d;
            k_q         <= k_d;
            p_q         <= p_d;
            first_q     <= (state_q == S_FETCH);
            msg_ready_q <= msg_ready_d;
            gen_rd_q    <= gen_rd_d;
            gen_addr_q  <= gen_addr_d;
            par_valid_q <= par_valid_d;
            par_data_q  <= par_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.msg_ready = msg_ready_q;
    assign bus.gen_rd    = gen_rd_q;
    assign bus.gen_addr  = gen_addr_q;
    assign bus.par_valid = par_valid_q;
    assign bus.par_data  = par_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_qc_ldpc_encoder.sv
// Bench for qc_ldpc_encoder at Z=8, KB=3, MB=2: directed vector table plus
// randomized codewords against a circulant-product reference model.
module tb_qc_ldpc_encoder;
    localparam int unsigned Z      = 8;
    localparam int unsigned KB     = 3;
    localparam int unsigned MB     = 2;
    localparam int unsigned AW     = 2;
    localparam int          BUDGET = 2000;
    localparam int          NVEC   = 9;
    localparam int          NCYC   = 1 + KB * (Z + 2) + MB;

    typedef logic [KB-1:0][Z-1:0]    msgs_t;
    typedef logic [KB-1:0][MB*Z-1:0] rom_t;
    typedef logic [MB-1:0][Z-1:0]    par_t;

    typedef struct packed {
        msgs_t msg;
        rom_t  g;
        par_t  exp;
    } vec_t;

    logic clk, rst, start, busy, done;
    int   checks, failures;
    rom_t rom_cur;
    int   addr_log[$];
    logic          rom_rd_s;
    logic [AW-1:0] rom_addr_s;

    qc_ldpc_encoder_if #(.Z(Z), .MB(MB), .AW(AW)) gif ();

    qc_ldpc_encoder #(.Z(Z), .KB(KB), .MB(MB), .AW(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .busy (busy),
        .done (done),
        .bus  (gif.master)
    );

    always #5 clk = ~clk;

    // Generator ROM: data valid only the cycle after a read, junk otherwise
    always @(posedge clk) begin
        rom_rd_s   = gif.gen_rd;
        rom_addr_s = gif.gen_addr;
        #1;
        if (rom_rd_s) begin
            gif.gen_data = rom_cur[rom_addr_s];
            addr_log.push_back(int'(rom_addr_s));
        end else begin
            gif.gen_data = (MB*Z)'($urandom);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [Z-1:0] rotl(input logic [Z-1:0] x, input int k);
        logic [2*Z-1:0] d;
        d = {x, x};
        return d[2*Z-1-k -: Z];
    endfunction

    // Parity block i = sum over blocks j and set message bits k of row k of G(j,i)
    function automatic par_t model(input msgs_t m, input rom_t g);
        par_t r;
        logic [Z-1:0] row;
        r = '0;
        for (int i = 0; i < MB; i++)
            for (int j = 0; j < KB; j++) begin
                row = g[j][i*Z +: Z];
                for (int k = 0; k < Z; k++)
                    if (m[j][k]) r[i] = r[i] ^ rotl(row, k);
            end
        return r;
    endfunction

    task automatic run_cw(input msgs_t m, input rom_t g, input int delay, input bit stall,
                          input bit spulse, output par_t got, output int ncyc, output int nout);
        int blk, wcnt, extra_done;
        bit mf, pf, hold, seen_out, got_done;
        logic [Z-1:0] hv;
        rom_cur = g;
        addr_log.delete();
        got = '0; nout = 0; ncyc = 0; blk = 0; wcnt = 0; seen_out = 0; got_done = 0;
        start = 1'b1;
        gif.msg_valid = (delay == 0);
        gif.msg_data  = m[0];
        gif.par_ready = 1'b1;
        for (int t = 0; t < BUDGET; t++) begin
            mf   = gif.msg_valid && gif.msg_ready;
            pf   = gif.par_valid && gif.par_ready;
            hold = gif.par_valid && !gif.par_ready;
            hv   = gif.par_data;
            if (pf) begin
                if (nout < MB) got[nout] = gif.par_data;
                nout++;
            end
            @(posedge clk); #1;
            ncyc++;
            start = 1'b0;
            if (hold) chk("par_hold", 64'(gif.par_data), 64'(hv));
            if (mf) begin
                blk++;
                wcnt = 0;
            end
            if (done) begin
                got_done = 1;
                chk("busy_in_done", 64'(busy), 64'd1);
                break;
            end
            if (gif.msg_ready) wcnt++;
            gif.msg_valid = (blk < KB) && (delay == 0 || wcnt > delay);
            gif.msg_data  = gif.msg_valid ? m[blk] : Z'($urandom);
            gif.par_ready = !stall || (ncyc % 2 == 1);
            if (spulse && (ncyc == 5 || (gif.par_valid && !seen_out))) start = 1'b1;
            if (gif.par_valid) seen_out = 1;
        end
        chk("done_seen", 64'(got_done), 64'd1);
        gif.msg_valid = 1'b1;
        gif.par_ready = 1'b1;
        extra_done = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        chk("extra_done", 64'(extra_done), 64'd0);
        chk("idle_after", 64'({busy, gif.par_valid, gif.msg_ready}), 64'd0);
        gif.msg_valid = 1'b0;
    endtask

    task automatic check_run(input string tag, input msgs_t m, input rom_t g, input par_t exp,
                             input int delay, input bit stall, input bit spulse);
        par_t got;
        int ncyc, nout;
        run_cw(m, g, delay, stall, spulse, got, ncyc, nout);
        chk({tag, "_nout"}, 64'(nout), 64'(MB));
        chk({tag, "_par"}, 64'(got), 64'(exp));
        if (delay == 0 && !stall) chk({tag, "_cycles"}, 64'(ncyc), 64'(NCYC));
        chk({tag, "_nrd"}, 64'(addr_log.size()), 64'(KB));
        for (int i = 0; i < addr_log.size() && i < KB; i++)
            chk({tag, "_addr"}, 64'(addr_log[i]), 64'(i));
    endtask

    initial begin
        vec_t vecs[NVEC];
        msgs_t rm;
        rom_t  rg;

        checks = 0; failures = 0;
        clk = 0; rst = 1; start = 0;
        gif.msg_valid = 0; gif.msg_data = '0; gif.par_ready = 0; gif.gen_data = '0;
        rom_cur = '0;

        vecs[0] = '{msg: {8'h00, 8'h00, 8'h00}, g: {16'hBEEF, 16'h1234, 16'hA5C3}, exp: {8'h00, 8'h00}};
        vecs[1] = '{msg: {8'h00, 8'h00, 8'h20}, g: {16'h0000, 16'h0000, 16'h0001}, exp: {8'h00, 8'h20}};
        vecs[2] = '{msg: {8'h00, 8'h00, 8'h01}, g: {16'h0000, 16'h0000, 16'h0081}, exp: {8'h00, 8'h81}};
        vecs[3] = '{msg: {8'h00, 8'h00, 8'h02}, g: {16'h0000, 16'h0000, 16'h0081}, exp: {8'h00, 8'h03}};
        vecs[4] = '{msg: {8'h00, 8'hC3, 8'hC3}, g: {16'h0000, 16'h5A00, 16'h5A00}, exp: {8'h00, 8'h00}};
        vecs[5] = '{msg: {8'h00, 8'h00, 8'hC3}, g: {16'h0000, 16'h5A00, 16'h5A00}, exp: {8'h55, 8'h00}};
        vecs[6] = '{msg: {8'h00, 8'h00, 8'h80}, g: {16'h0000, 16'h0000, 16'h0001}, exp: {8'h00, 8'h80}};
        vecs[7] = '{msg: {8'h00, 8'h00, 8'hFF}, g: {16'h0000, 16'h0000, 16'h0001}, exp: {8'h00, 8'hFF}};
        vecs[8] = '{msg: {8'h01, 8'h00, 8'h00}, g: {16'h0300, 16'h0000, 16'h0000}, exp: {8'h03, 8'h00}};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 64'({gif.msg_ready, gif.par_valid, busy, done, gif.gen_rd}), 64'd0);
        chk("rst_par_data", 64'(gif.par_data), 64'd0);
        chk("rst_gen_addr", 64'(gif.gen_addr), 64'd0);
        rst = 0;
        @(posedge clk); #1;

        for (int v = 0; v < NVEC; v++)
            check_run($sformatf("vec%0d", v), vecs[v].msg, vecs[v].g, vecs[v].exp, 0, 0, 0);

        // Reset in the middle of ACCUM, then a clean codeword must be unaffected
        rom_cur = vecs[5].g;
        start = 1; gif.msg_valid = 1; gif.msg_data = vecs[5].msg[0]; gif.par_ready = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_mid", 64'(busy), 64'd1);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_outputs", 64'({gif.msg_ready, gif.par_valid, busy, done, gif.gen_rd}), 64'd0);
        rst = 0;
        gif.msg_valid = 0;
        @(posedge clk); #1;
        chk("midrst_idle", 64'(busy), 64'd0);
        check_run("after_rst", vecs[5].msg, vecs[5].g, vecs[5].exp, 0, 0, 0);

        // Random codewords: plain, backpressured and with ignored start pulses
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < KB; j++) begin
                rm[j] = Z'($urandom);
                rg[j] = (MB*Z)'($urandom);
            end
            check_run($sformatf("rnd%0d_plain", r), rm, rg, model(rm, rg), 0, 0, 0);
            if (r % 2 == 0)
                check_run($sformatf("rnd%0d_stall", r), rm, rg, model(rm, rg), 10, 1, 0);
            else
                check_run($sformatf("rnd%0d_spulse", r), rm, rg, model(rm, rg), 0, 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
